// File: rtl/bcd_scan_counter_if.sv
// Control and display bundle between the BCD scan counter and its consumer:
// the count enables come in, and the count plus scanned digit data go out.
interface bcd_scan_counter_if;
   logic        en;
   logic        clr;
   logic [15:0] count;
   logic [3:0]  digit;
   logic [3:0]  an;
   logic        ovf;
   logic        ovf_sticky;

   modport master (
      output en,
      output clr,
      input  count,
      input  digit,
      input  an,
      input  ovf,
      input  ovf_sticky
   );

   modport slave (
      input  en,
      input  clr,
      output count,
      output digit,
      output an,
      output ovf,
      output ovf_sticky
   );
endinterface

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up-counter with wrap/overflow flags and a common-anode digit
// scanner that feeds a 7-segment decoder, with optional leading-zero blanking.
module bcd_scan_counter #(
   parameter int TICK_DIV = 100000000,
   parameter int SCAN_DIV = 100000,
   parameter int BLANK_LZ = 1
) (
   input  logic              clk,
   input  logic              rst,
   bcd_scan_counter_if.slave bus
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      SCAN_UNITS    = 2'd0,
      SCAN_TENS     = 2'd1,
      SCAN_HUNDREDS = 2'd2,
      SCAN_THOUS    = 2'd3
   } scan_state_t;

   // Ripple-carry BCD increment; bit 16 is the carry out of the thousands digit.
   function automatic logic [16:0] bcd_inc(input logic [15:0] value);
      logic [15:0] result;
      logic [3:0]  nib;
      logic        carry;
      carry  = 1'b1;
      result = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         nib = value[4*i +: 4];
         if (carry && (nib == 4'd9)) begin
            result[4*i +: 4] = 4'd0;
         end else if (carry) begin
            result[4*i +: 4] = nib + 4'd1;
            carry            = 1'b0;
         end else begin
            result[4*i +: 4] = nib;
         end
      end
      return {carry, result};
   endfunction

   logic [PW-1:0] presc_r;
   logic [15:0]   count_r;
   logic          ovf_r;
   logic          ovf_sticky_r;
   logic          tick_s;
   logic [16:0]   inc_s;

   logic [SW-1:0] scan_cnt_r;
   logic          scan_wrap_s;
   scan_state_t   scan_state_r;
   scan_state_t   scan_state_next_s;
   logic [3:0]    an_r;
   logic [3:0]    digit_r;
   logic [3:0]    an_next_s;
   logic [3:0]    digit_next_s;
   logic [3:0]    nib_s;
   logic          blank_s;

   assign tick_s      = bus.en && (presc_r == PRESC_LAST);
   assign inc_s       = bcd_inc(count_r);
   assign scan_wrap_s = (scan_cnt_r == SCAN_LAST);

   // Prescaler, count value and overflow flags; clr outranks any tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_r      <= '0;
         count_r      <= 16'h0000;
         ovf_r        <= 1'b0;
         ovf_sticky_r <= 1'b0;
      end else if (bus.clr) begin
         presc_r      <= '0;
         count_r      <= 16'h0000;
         ovf_r        <= 1'b0;
         ovf_sticky_r <= 1'b0;
      end else begin
         if (bus.en) begin
            presc_r <= tick_s ? '0 : presc_r + PW'(1);
         end
         if (tick_s) begin
            count_r      <= inc_s[15:0];
            ovf_r        <= inc_s[16];
            ovf_sticky_r <= ovf_sticky_r | inc_s[16];
         end else begin
            ovf_r <= 1'b0;
         end
      end
   end

   // Scan dwell counter, free-running regardless of en and clr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt_r <= '0;
      end else begin
         scan_cnt_r <= scan_wrap_s ? '0 : scan_cnt_r + SW'(1);
      end
   end

   // Scan index state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_state_r <= SCAN_UNITS;
      end else begin
         scan_state_r <= scan_state_next_s;
      end
   end

   // Next scan index plus the anode/digit pair it will present; a digit is
   // blank only when it and every more significant digit are zero.
   always_comb begin
      scan_state_next_s = scan_state_r;
      an_next_s         = 4'b1110;
      nib_s             = count_r[3:0];
      blank_s           = 1'b0;

      if (scan_wrap_s) begin
         case (scan_state_r)
            SCAN_UNITS:    scan_state_next_s = SCAN_TENS;
            SCAN_TENS:     scan_state_next_s = SCAN_HUNDREDS;
            SCAN_HUNDREDS: scan_state_next_s = SCAN_THOUS;
            SCAN_THOUS:    scan_state_next_s = SCAN_UNITS;
            default:       scan_state_next_s = SCAN_UNITS;
         endcase
      end else begin
         scan_state_next_s = scan_state_r;
      end

      case (scan_state_next_s)
         SCAN_UNITS: begin
            an_next_s = 4'b1110;
            nib_s     = count_r[3:0];
            blank_s   = 1'b0;
         end
         SCAN_TENS: begin
            an_next_s = 4'b1101;
            nib_s     = count_r[7:4];
            blank_s   = (count_r[15:4] == 12'h000);
         end
         SCAN_HUNDREDS: begin
            an_next_s = 4'b1011;
            nib_s     = count_r[11:8];
            blank_s   = (count_r[15:8] == 8'h00);
         end
         SCAN_THOUS: begin
            an_next_s = 4'b0111;
            nib_s     = count_r[15:12];
            blank_s   = (count_r[15:12] == 4'h0);
         end
         default: begin
            an_next_s = 4'b1110;
            nib_s     = count_r[3:0];
            blank_s   = 1'b0;
         end
      endcase

      if ((BLANK_LZ != 0) && blank_s) begin
         digit_next_s = 4'hF;
      end else begin
         digit_next_s = nib_s;
      end
   end

   // Anode and digit are loaded together so the display never sees a mixed pair.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_r    <= 4'b1110;
         digit_r <= 4'h0;
      end else begin
         an_r    <= an_next_s;
         digit_r <= digit_next_s;
      end
   end

   assign bus.count      = count_r;
   assign bus.digit      = digit_r;
   assign bus.an         = an_r;
   assign bus.ovf        = ovf_r;
   assign bus.ovf_sticky = ovf_sticky_r;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Randomized and directed bench for bcd_scan_counter: two configurations run in
// lockstep against an arithmetic reference model of count, flags and display.
module tb_bcd_scan_counter;

   logic clk;
   logic rst;

   bcd_scan_counter_if bus_a ();
   bcd_scan_counter_if bus_b ();

   bcd_scan_counter #(.TICK_DIV(1), .SCAN_DIV(2), .BLANK_LZ(1)) u_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   bcd_scan_counter #(.TICK_DIV(4), .SCAN_DIV(3), .BLANK_LZ(0)) u_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   int p_tdiv [2] = '{1, 4};
   int p_sdiv [2] = '{2, 3};
   int p_blz  [2] = '{1, 0};

   int       m_val    [2];
   int       m_presc  [2];
   int       m_scnt   [2];
   int       m_idx    [2];
   bit       m_ovf    [2];
   bit       m_sticky [2];
   logic [3:0] m_an   [2];
   logic [3:0] m_dig  [2];

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_val[i]    = 0;
         m_presc[i]  = 0;
         m_scnt[i]   = 0;
         m_idx[i]    = 0;
         m_ovf[i]    = 1'b0;
         m_sticky[i] = 1'b0;
         m_an[i]     = 4'b1110;
         m_dig[i]    = 4'h0;
      end
   endtask

   task automatic model_step(input bit en, input bit clr);
      for (int i = 0; i < 2; i++) begin
         bit tick;
         int p;
         tick = en && (m_presc[i] == p_tdiv[i] - 1);
         if (m_scnt[i] == p_sdiv[i] - 1) begin
            m_scnt[i] = 0;
            m_idx[i]  = (m_idx[i] + 1) % 4;
         end else begin
            m_scnt[i]++;
         end
         p = 1;
         for (int k = 0; k < m_idx[i]; k++) p *= 10;
         m_an[i] = ~(4'b0001 << m_idx[i]);
         if (p_blz[i] != 0 && m_idx[i] > 0 && m_val[i] < p) m_dig[i] = 4'hF;
         else m_dig[i] = 4'((m_val[i] / p) % 10);
         if (clr) begin
            m_val[i]    = 0;
            m_presc[i]  = 0;
            m_sticky[i] = 1'b0;
            m_ovf[i]    = 1'b0;
         end else begin
            if (en) m_presc[i] = tick ? 0 : m_presc[i] + 1;
            if (tick) begin
               m_ovf[i] = (m_val[i] == 9999);
               if (m_ovf[i]) m_sticky[i] = 1'b1;
               m_val[i] = (m_val[i] + 1) % 10000;
            end else begin
               m_ovf[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic check_all();
      check_val("a_count",  bus_a.count,            to_bcd(m_val[0]));
      check_val("a_digit",  {12'h000, bus_a.digit}, {12'h000, m_dig[0]});
      check_val("a_an",     {12'h000, bus_a.an},    {12'h000, m_an[0]});
      check_val("a_ovf",    {15'h0000, bus_a.ovf},  {15'h0000, m_ovf[0]});
      check_val("a_sticky", {15'h0000, bus_a.ovf_sticky}, {15'h0000, m_sticky[0]});
      check_val("b_count",  bus_b.count,            to_bcd(m_val[1]));
      check_val("b_digit",  {12'h000, bus_b.digit}, {12'h000, m_dig[1]});
      check_val("b_an",     {12'h000, bus_b.an},    {12'h000, m_an[1]});
      check_val("b_ovf",    {15'h0000, bus_b.ovf},  {15'h0000, m_ovf[1]});
      check_val("b_sticky", {15'h0000, bus_b.ovf_sticky}, {15'h0000, m_sticky[1]});
   endtask

   // One clock: drive inputs, advance the model at the edge, check at negedge.
   task automatic cyc(input bit en, input bit clr);
      bus_a.en  = en;
      bus_a.clr = clr;
      bus_b.en  = en;
      bus_b.clr = clr;
      @(posedge clk);
      if (rst) model_reset();
      else model_step(en, clr);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      int seen;
      rst       = 1'b1;
      bus_a.en  = 1'b0;
      bus_a.clr = 1'b0;
      bus_b.en  = 1'b0;
      bus_b.clr = 1'b0;
      model_reset();
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      rst = 1'b0;

      // Random enables with occasional clears.
      repeat (600) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);

      // Asynchronous reset between edges, then held across an edge.
      do_reset();
      repeat (37) cyc(1'b1, 1'b0);
      #1 rst = 1'b1;
      #1 model_reset();
      check_all();
      check_val("mid_rst_count", bus_a.count, 16'h0000);
      check_val("mid_rst_an", {12'h000, bus_a.an}, 16'h000E);
      cyc(1'b1, 1'b0);
      check_val("rst_hold_count", bus_a.count, 16'h0000);
      rst = 1'b0;

      // BCD carry into tens and hundreds.
      do_reset();
      repeat (10) cyc(1'b1, 1'b0);
      check_val("carry_10", bus_a.count, 16'h0010);
      repeat (90) cyc(1'b1, 1'b0);
      check_val("carry_100", bus_a.count, 16'h0100);

      // Wrap 9999 -> 0000 with a single-cycle ovf pulse.
      do_reset();
      repeat (9999) cyc(1'b1, 1'b0);
      check_val("pre_wrap_count", bus_a.count, 16'h9999);
      check_val("pre_wrap_ovf", {15'h0000, bus_a.ovf}, 16'h0000);
      cyc(1'b1, 1'b0);
      check_val("wrap_count", bus_a.count, 16'h0000);
      check_val("wrap_ovf", {15'h0000, bus_a.ovf}, 16'h0001);
      check_val("wrap_sticky", {15'h0000, bus_a.ovf_sticky}, 16'h0001);
      cyc(1'b1, 1'b0);
      check_val("post_wrap_ovf", {15'h0000, bus_a.ovf}, 16'h0000);
      check_val("post_wrap_sticky", {15'h0000, bus_a.ovf_sticky}, 16'h0001);

      // Clear in the wrapping tick cycle wins.
      do_reset();
      repeat (9999) cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b1);
      check_val("clr_wrap_count", bus_a.count, 16'h0000);
      check_val("clr_wrap_ovf", {15'h0000, bus_a.ovf}, 16'h0000);
      check_val("clr_wrap_sticky", {15'h0000, bus_a.ovf_sticky}, 16'h0000);
      cyc(1'b1, 1'b0);
      check_val("clr_wrap_ovf2", {15'h0000, bus_a.ovf}, 16'h0000);
      repeat (9999) cyc(1'b1, 1'b0);
      check_val("sticky_set", {15'h0000, bus_a.ovf_sticky}, 16'h0001);
      cyc(1'b0, 1'b1);
      check_val("sticky_clr", {15'h0000, bus_a.ovf_sticky}, 16'h0000);

      // Scan and leading-zero blanking with count held at 0305.
      do_reset();
      repeat (305) cyc(1'b1, 1'b0);
      check_val("scan_count", bus_a.count, 16'h0305);
      seen = 0;
      for (int c = 0; c < 16; c++) begin
         cyc(1'b0, 1'b0);
         if (bus_a.an == 4'b0111 && bus_a.digit == 4'hF) seen++;
      end
      check_val("scan_thous_blank", 16'(seen), 16'd4);

      // Enable gating on the divide-by-4 instance.
      do_reset();
      repeat (2) cyc(1'b1, 1'b0);
      repeat (10) begin
         cyc(1'b0, 1'b0);
         check_val("gate_hold", bus_b.count, 16'h0000);
      end
      cyc(1'b1, 1'b0);
      check_val("gate_pre", bus_b.count, 16'h0000);
      cyc(1'b1, 1'b0);
      check_val("gate_inc", bus_b.count, 16'h0001);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
